serial_word_receiver: RTL and testbench
=======================================

Name: serial_word_receiver

Overview:
- Serial-to-parallel receiving end for a bit stream produced by the team's shift-register serial outputs.
- Collects framed serial bits into WIDTH-bit words and presents each word on a valid/ready parallel interface.
- Holds completed words in an output buffer separate from the shift register, so reception continues while the consumer stalls.
- Sits between a serial link and any parallel consumer.

Parameters:
- WIDTH, 4: data bits per word; legal range 2..16.
- MSB_FIRST, 1: 1 = first received bit lands in out_data[WIDTH-1]; 0 = first received bit lands in out_data[0].

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- sin  input  1  serial data bit.
- sin_valid  input  1  strobe; sin is sampled only on edges where sin_valid=1.
- frame  input  1  qualifies the first bit of a word; meaningful only when sin_valid=1.
- out_data  output  WIDTH  received word, registered.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts out_data on an edge where out_valid=1 and out_ready=1.
- busy  output  1  word reception in progress (state != IDLE).
- overflow  output  1  sticky: a completed word was dropped.
- ovf_clr  input  1  synchronous clear of overflow.
- resync  output  1  one-cycle pulse: a partial word was discarded by a new frame.

Behaviour:
- Clock and reset: one clock clk; reset rst is asynchronous and active-high.
- Reset values: shift register, bit counter, out_data = 0; out_valid = 0; busy = 0; overflow = 0; resync = 0; state = IDLE. Reset asserted mid-word discards the partial word and any buffered word.
- State IDLE:
  - sin_valid=1 and frame=1: shift in sin, cnt=1, go to RECV.
  - sin_valid=1 and frame=0: bit ignored, stay in IDLE.
- State RECV, sin_valid=1 and frame=0:
  - Shift in sin, cnt+1.
  - When this bit is bit number WIDTH, the word is complete: go to IDLE (or PARITY when the optional feature is enabled).
- State RECV, sin_valid=1 and frame=1:
  - Discard the partial word.
  - Take this bit as bit 1 of a new word, set cnt=1, pulse resync for 1 cycle, stay in RECV.
- sin_valid=0: no state change, in any state.
- Shift direction:
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], sin}.
  - MSB_FIRST=0: sr <= {sin, sr[WIDTH-1:1]}.
- Word completion and output buffer:
  - The completing word is written to out_data on the same edge that accepts its final bit; out_valid is visible from the next cycle.
  - Latency: 0 cycles after the last-bit edge.
  - Buffer empty, or out_valid=1 with out_ready=1 on the same edge: load the new word; out_valid stays or becomes 1; no overflow.
  - out_valid=1 with out_ready=0: the new word is dropped, out_data is unchanged, overflow is set.
- Handshake:
  - out_data is stable while out_valid=1.
  - out_valid clears on an edge where out_ready=1 unless a new word loads on that same edge.
  - out_ready while out_valid=0 has no effect.
- overflow: stays set until ovf_clr=1. If a set condition and ovf_clr=1 occur on the same edge, the set wins.
- Counter width: clog2(WIDTH+1) bits. The counter resets to 0 on entry to IDLE; no wrap-around.

Optional Feature:
- Macro: SWR_PARITY_EN.
- Defined:
  - After WIDTH data bits, the block enters state PARITY and expects one more sin_valid bit with frame=0 (a frame during PARITY behaves as in RECV).
  - That bit is an even-parity bit: the XOR of data and parity must be 0.
  - The word is loaded into out_data on the parity-bit edge, with the same rules as word completion above.
  - Extra output parity_err (1 bit): set for the loaded word on mismatch; updates only when a word loads; reset value 0.
  - A dropped word does not update parity_err.
- Undefined: no PARITY state and no parity_err port; the word completes on data bit WIDTH.

Test Plan:
- WIDTH=4, MSB_FIRST=1; bits 1,0,1,1 on consecutive edges, frame on the first bit, out_ready=0 -> out_data=4'b1011, out_valid=1 the cycle after the 4th bit, busy=0.
- MSB_FIRST=0, same bits -> out_data=4'b1101.
- Word 4'b1011 held with out_ready=0, then word 4'b0110 sent -> out_data stays 4'b1011, overflow=1. Pulse ovf_clr -> overflow=0.
- Frame mid-word: bits 1,1 then frame with 0,0,0,1 -> resync pulses once, out_data=4'b0001.
- Back-to-back words with out_ready=1 held high, and completion coinciding with the accept edge -> both words delivered in order; overflow stays 0.
- Reset asserted after 2 bits with a word buffered -> out_valid=0 immediately (asynchronous). A following framed 4-bit word is received correctly. With SWR_PARITY_EN: data 1011 + parity 1 -> parity_err=0; data 1011 + parity 0 -> parity_err=1.

Source files
------------

// File: rtl/serial_word_receiver.sv
// serial_word_receiver
//   Collects framed serial bits into WIDTH-bit words and hands each finished
//   word to a parallel consumer through a one-entry output buffer. The shift
//   register and the output buffer are separate, so reception carries on
//   while the consumer stalls.
//
//   Optional feature: define SWR_PARITY_EN to expect one even-parity bit after
//   the data bits. It adds a PARITY state and the parity_err output.
//
//   Handshake: a word is transferred on any rising edge where out_valid=1 and
//   out_ready=1. out_data is stable while out_valid=1. out_ready while
//   out_valid=0 has no effect.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   sin        serial data bit, sampled only when sin_valid=1
//   sin_valid  serial strobe
//   frame      marks the first bit of a word (used only when sin_valid=1)
//   out_data   received word (registered)
//   out_valid  out_data holds an unconsumed word
//   out_ready  consumer accepts out_data
//   busy       a word is being received (state != IDLE)
//   overflow   sticky: a completed word was dropped
//   ovf_clr    synchronous clear of overflow (a same-edge set wins)
//   resync     one-cycle pulse: a partial word was discarded by a new frame
//   parity_err (SWR_PARITY_EN only) parity mismatch of the loaded word
module serial_word_receiver #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             frame,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overflow,
    input  logic             ovf_clr,
    output logic             resync
`ifdef SWR_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef SWR_PARITY_EN
    typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_PARITY} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_RECV} state_t;
`endif

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              overflow_q, overflow_d;
    logic              resync_q, resync_d;
`ifdef SWR_PARITY_EN
    logic              parity_err_q, parity_err_d;
    logic              word_perr;
`endif

    logic [WIDTH-1:0]  shifted;
    logic [WIDTH-1:0]  word;
    logic              word_done;

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overflow_d  = overflow_q;
        resync_d    = 1'b0;
        word_done   = 1'b0;
`ifdef SWR_PARITY_EN
        parity_err_d = parity_err_q;
        word_perr    = 1'b0;
`endif

        if (MSB_FIRST != 0) begin
            shifted = {sr_q[WIDTH-2:0], sin};
        end else begin
            shifted = {sin, sr_q[WIDTH-1:1]};
        end
        word = shifted;

        if (sin_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (frame) begin
                        sr_d    = shifted;
                        cnt_d   = CNT_W'(1);
                        state_d = ST_RECV;
                    end
                end
                ST_RECV: begin
                    sr_d = shifted;
                    if (frame) begin
                        // Stale bits of the abandoned word are shifted out by
                        // the time the new word completes, so no clear needed.
                        cnt_d    = CNT_W'(1);
                        resync_d = 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
`ifdef SWR_PARITY_EN
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = ST_PARITY;
`else
                        cnt_d     = '0;
                        state_d   = ST_IDLE;
                        word_done = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`ifdef SWR_PARITY_EN
                ST_PARITY: begin
                    if (frame) begin
                        sr_d     = shifted;
                        cnt_d    = CNT_W'(1);
                        resync_d = 1'b1;
                        state_d  = ST_RECV;
                    end else begin
                        // Data already complete in sr_q; this bit is parity only.
                        word      = sr_q;
                        word_perr = ^{sr_q, sin};
                        word_done = 1'b1;
                        cnt_d     = '0;
                        state_d   = ST_IDLE;
                    end
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (ovf_clr) begin
            overflow_d = 1'b0;
        end
        // A word finishing on the accept edge refills the freed buffer.
        if (word_done) begin
            if (!out_valid_q || out_ready) begin
                out_data_d  = word;
                out_valid_d = 1'b1;
`ifdef SWR_PARITY_EN
                parity_err_d = word_perr;
`endif
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            resync_q    <= 1'b0;
`ifdef SWR_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            resync_q    <= resync_d;
`ifdef SWR_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;
    assign resync    = resync_q;
    assign busy      = (state_q != ST_IDLE);
`ifdef SWR_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_serial_word_receiver.sv
// Bench for serial_word_receiver: two instances (MSB-first and LSB-first)
// share one serial stream. A bit-queue reference model predicts every output
// each cycle; delivered words are checked in order against exp_q.
module tb_serial_word_receiver;

    localparam int W = 4;
`ifdef SWR_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic clk = 1'b0;
    logic rst;
    logic sin, sin_valid, frame, out_ready, ovf_clr;
    logic [W-1:0] out_data_m, out_data_l;
    logic out_valid_m, out_valid_l, busy_m, busy_l;
    logic overflow_m, overflow_l, resync_m, resync_l;
`ifdef SWR_PARITY_EN
    logic parity_err_m, parity_err_l;
`endif

    // ---------------- clock / DUTs ----------------
    always #5 clk = ~clk;

    serial_word_receiver #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .frame(frame),
        .out_data(out_data_m), .out_valid(out_valid_m), .out_ready(out_ready),
        .busy(busy_m), .overflow(overflow_m), .ovf_clr(ovf_clr), .resync(resync_m)
`ifdef SWR_PARITY_EN
        , .parity_err(parity_err_m)
`endif
    );

    serial_word_receiver #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .frame(frame),
        .out_data(out_data_l), .out_valid(out_valid_l), .out_ready(out_ready),
        .busy(busy_l), .overflow(overflow_l), .ovf_clr(ovf_clr), .resync(resync_l)
`ifdef SWR_PARITY_EN
        , .parity_err(parity_err_l)
`endif
    );

    // ---------------- scoreboard / model state ----------------
    int n_cmp = 0;
    int n_err = 0;
    int resync_seen = 0;

    bit           bits[$];          // bits of the word being received, in arrival order
    bit           in_word;
    logic [W-1:0] exp_data_m, exp_data_l;
    bit           exp_valid, exp_ovf, exp_resync, exp_perr;
    logic [W-1:0] exp_q[$];         // words expected to be delivered, oldest first

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        bits.delete();
        in_word    = 0;
        exp_data_m = '0;
        exp_data_l = '0;
        exp_valid  = 0;
        exp_ovf    = 0;
        exp_resync = 0;
        exp_perr   = 0;
        exp_q.delete();
    endtask

    // One clock edge of the reference behaviour.
    task automatic model_step(input bit s, input bit sv, input bit fr, input bit rdy, input bit clr);
        bit           done = 0;
        bit           p = 0;
        logic [W-1:0] m = '0;
        logic [W-1:0] l = '0;
        exp_resync = 0;
        if (sv) begin
            if (fr) begin
                exp_resync = in_word;
                bits.delete();
                bits.push_back(s);
                in_word = 1;
            end else if (in_word) begin
                bits.push_back(s);
            end
        end
        if (in_word && bits.size() == NB) begin
            for (int i = 0; i < W; i++) begin
                m[W-1-i] = bits[i];
                l[i]     = bits[i];
            end
            for (int i = 0; i < NB; i++) p ^= bits[i];
            done = 1;
            in_word = 0;
            bits.delete();
        end
        if (clr) exp_ovf = 0;
        if (done && exp_valid && !rdy) begin
            exp_ovf = 1;
        end else if (done) begin
            exp_data_m = m;
            exp_data_l = l;
            exp_perr   = p;
            exp_valid  = 1;
            exp_q.push_back(m);
        end else if (exp_valid && rdy) begin
            exp_valid = 0;
        end
    endtask

    task automatic check_outputs();
        check("valid_m", out_valid_m, exp_valid);
        check("valid_l", out_valid_l, exp_valid);
        check("data_m", out_data_m, exp_data_m);
        check("data_l", out_data_l, exp_data_l);
        check("busy_m", busy_m, in_word);
        check("busy_l", busy_l, in_word);
        check("ovf_m", overflow_m, exp_ovf);
        check("ovf_l", overflow_l, exp_ovf);
        check("resync_m", resync_m, exp_resync);
        check("resync_l", resync_l, exp_resync);
`ifdef SWR_PARITY_EN
        check("perr_m", parity_err_m, exp_perr);
        check("perr_l", parity_err_l, exp_perr);
`endif
        if (resync_m === 1'b1) resync_seen++;
    endtask

    // ---------------- driver tasks (called #1 after a rising edge) ----------------
    task automatic cycle(input bit s, input bit sv, input bit fr, input bit rdy, input bit clr);
        sin = s; sin_valid = sv; frame = fr; out_ready = rdy; ovf_clr = clr;
        if (out_valid_m === 1'b1 && rdy) begin
            check("deliver_q_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("deliver_order", out_data_m, exp_q.pop_front());
        end
        model_step(s, sv, fr, rdy, clr);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input bit rdy, input bit clr);
        cycle(0, 0, 0, rdy, clr);
    endtask

    // w is given first-bit-first as w[W-1] .. w[0]; a correct even-parity bit
    // follows when parity is enabled. rdy_last applies to the final edge.
    task automatic send_word(input logic [W-1:0] w, input bit rdy, input bit rdy_last);
        for (int i = 0; i < NB; i++) begin
            bit b;
            b = (i < W) ? w[W-1-i] : ^w;
            cycle(b, 1, i == 0, (i == NB - 1) ? rdy_last : rdy, 0);
        end
    endtask

    task automatic do_reset();
        rst = 1; sin = 0; sin_valid = 0; frame = 0; out_ready = 0; ovf_clr = 0;
        #1;
        check("rst_async_valid_m", out_valid_m, 0);
        check("rst_async_valid_l", out_valid_l, 0);
        check("rst_async_busy", busy_m, 0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int rs0;
        do_reset();
        idle(0, 0);
        check("reset_data", out_data_m, 0);

        // Basic word, both bit orders, consumer stalled.
        send_word(4'b1011, 0, 0);
        check("tp1_data_msb", out_data_m, 4'b1011);
        check("tp1_data_lsb", out_data_l, 4'b1101);
        check("tp1_valid", out_valid_m, 1);
        check("tp1_busy", busy_m, 0);

        // Second word while the first is held: dropped, overflow sticky.
        send_word(4'b0110, 0, 0);
        check("tp3_hold", out_data_m, 4'b1011);
        check("tp3_ovf", overflow_m, 1);
        idle(0, 0);
        check("tp3_ovf_sticky", overflow_m, 1);
        idle(0, 1);
        check("tp3_ovf_clr", overflow_m, 0);
        idle(1, 0);
        check("tp3_drained", out_valid_m, 0);

        // New frame mid-word.
        rs0 = resync_seen;
        cycle(1, 1, 1, 0, 0);
        cycle(1, 1, 0, 0, 0);
        send_word(4'b0001, 0, 0);
        idle(0, 0);
        check("tp4_resync_count", resync_seen - rs0, 1);
        check("tp4_data_msb", out_data_m, 4'b0001);
        check("tp4_data_lsb", out_data_l, 4'b1000);
        idle(1, 0);

        // Back-to-back words with out_ready held high.
        send_word(4'b0101, 1, 1);
        check("tp5_w1", out_data_m, 4'b0101);
        send_word(4'b1110, 1, 1);
        check("tp5_w2", out_data_m, 4'b1110);
        check("tp5_ovf", overflow_m, 0);
        idle(1, 0);
        // Completion on the same edge as the accept of the buffered word.
        send_word(4'b0011, 0, 0);
        send_word(4'b1001, 0, 1);
        check("tp5_coincide_data", out_data_m, 4'b1001);
        check("tp5_coincide_valid", out_valid_m, 1);
        check("tp5_coincide_ovf", overflow_m, 0);
        idle(1, 0);

        // Reset mid-word with a word buffered.
        send_word(4'b1010, 0, 0);
        cycle(1, 1, 1, 0, 0);
        cycle(0, 1, 0, 0, 0);
        do_reset();
        send_word(4'b1011, 0, 0);
        check("tp6_after_rst", out_data_m, 4'b1011);
        check("tp6_after_rst_lsb", out_data_l, 4'b1101);
        idle(1, 0);

`ifdef SWR_PARITY_EN
        send_word(4'b1011, 0, 0);
        check("par_good", parity_err_m, 0);
        idle(1, 0);
        cycle(1, 1, 1, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        check("par_bad", parity_err_m, 1);
        check("par_bad_data", out_data_m, 4'b1011);
        idle(1, 0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            bit sv, fr;
            sv = ($urandom_range(0, 3) != 0);
            fr = in_word ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 2) == 0);
            cycle($urandom_range(0, 1), sv, fr, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 19) == 0);
        end

        check("sb_leftover", exp_q.size(), exp_valid);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
